// File: rtl/dispatch_router_if.sv
// Rename-to-issue handshake bundle for dispatch_router.
// Valid/ready: a transfer happens on a clk edge where valid and ready are both 1; valid never waits on ready.
interface dispatch_router_if #(
    parameter int DATA_W = 64,
    parameter int NUM_IQ = 3,
    parameter int SEL_W  = 2,
    parameter int TAG_W  = 5
);
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_in;
    logic [SEL_W-1:0]  sel_in;
    logic [NUM_IQ-1:0] iq_valid_out;
    logic [NUM_IQ-1:0] iq_ready_in;
    logic [DATA_W-1:0] iq_data_out;
    logic [TAG_W-1:0]  iq_tag_out;

    modport slave (
        input  valid_in, data_in, sel_in, iq_ready_in,
        output ready_out, iq_valid_out, iq_data_out, iq_tag_out
    );

    modport master (
        output valid_in, data_in, sel_in, iq_ready_in,
        input  ready_out, iq_valid_out, iq_data_out, iq_tag_out
    );
endinterface

// File: rtl/dispatch_router.sv
// Dispatch stage: small input FIFO, ROB tag allocation and routing to NUM_IQ issue queues.
// Mispredict flushes the FIFO and rewinds the ROB tail; reset overrides everything.
module dispatch_router #(
    parameter int DATA_W    = 64,
    parameter int NUM_IQ    = 3,
    parameter int SEL_W     = 2,
    parameter int BUF_DEPTH = 4,
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    dispatch_router_if.slave           bus,
    input  logic                       commit_in,
    input  logic                       mispredict,
    input  logic [TAG_W-1:0]           recover_tail_in,
    output logic [$clog2(BUF_DEPTH):0] buf_count_out,
    output logic [TAG_W-1:0]           rob_count_out,
    output logic                       sel_err_out
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [TAG_W-1:0] ROB_FULL = TAG_W'(ROB_DEPTH);

    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_d [BUF_DEPTH];
    logic [SEL_W-1:0]  buf_sel_q  [BUF_DEPTH];
    logic [SEL_W-1:0]  buf_sel_d  [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  buf_count_q, buf_count_d;
    logic [TAG_W-1:0]  rob_head_q, rob_head_d;
    logic [TAG_W-1:0]  rob_tail_q, rob_tail_d;
    logic              sel_err_q, sel_err_d;

    logic [TAG_W-1:0]  rob_count;
    logic [SEL_W-1:0]  head_sel;
    logic              head_sel_ok;
    logic              buf_empty;
    logic              accept;
    logic              push;
    logic              head_ok;
    logic [NUM_IQ-1:0] iq_valid;
    logic              fire;
    logic              drop;
    logic              pop;
    logic              commit_ok;

    always_comb begin
        rob_count   = rob_tail_q - rob_head_q;
        head_sel    = buf_sel_q[rd_ptr_q];
        head_sel_ok = 32'(head_sel) < 32'(NUM_IQ);
        buf_empty   = (buf_count_q == '0);
        accept      = (buf_count_q != BUF_FULL) && !mispredict;
        push        = bus.valid_in && accept;
        head_ok     = !buf_empty && (rob_count < ROB_FULL) && !mispredict;
        iq_valid    = (head_ok && head_sel_ok) ? (NUM_IQ'(1) << head_sel) : '0;
        fire        = |(iq_valid & bus.iq_ready_in);
        // An out-of-range select is discarded without consuming a ROB slot.
        drop        = !buf_empty && !head_sel_ok && !mispredict;
        pop         = fire || drop;
        commit_ok   = commit_in && (rob_count != '0);
    end

    always_comb begin
        buf_data_d  = buf_data_q;
        buf_sel_d   = buf_sel_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_count_d = buf_count_q;
        rob_head_d  = rob_head_q;
        rob_tail_d  = rob_tail_q;
        sel_err_d   = sel_err_q;

        if (commit_ok) rob_head_d = rob_head_q + TAG_W'(1);

        if (mispredict) begin
            rd_ptr_d    = wr_ptr_q;
            buf_count_d = '0;
            rob_tail_d  = recover_tail_in;
        end else begin
            if (push) begin
                buf_data_d[wr_ptr_q] = bus.data_in;
                buf_sel_d[wr_ptr_q]  = bus.sel_in;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop)  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            if (fire) rob_tail_d = rob_tail_q + TAG_W'(1);
            if (drop) sel_err_d  = 1'b1;
            case ({push, pop})
                2'b10:   buf_count_d = buf_count_q + CNT_W'(1);
                2'b01:   buf_count_d = buf_count_q - CNT_W'(1);
                default: buf_count_d = buf_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            buf_count_q <= '0;
            rob_head_q  <= '0;
            rob_tail_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_count_q <= buf_count_d;
            rob_head_q  <= rob_head_d;
            rob_tail_q  <= rob_tail_d;
            sel_err_q   <= sel_err_d;
        end
    end

    // Payload storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_sel_q  <= buf_sel_d;
    end

    // Outputs are forced low while reset is held, before the first edge clears state.
    assign bus.ready_out    = reset && accept;
    assign bus.iq_valid_out = reset ? iq_valid : '0;
    assign bus.iq_data_out  = reset ? buf_data_q[rd_ptr_q] : '0;
    assign bus.iq_tag_out   = reset ? rob_tail_q : '0;
    assign buf_count_out    = reset ? buf_count_q : '0;
    assign rob_count_out    = reset ? rob_count : '0;
    assign sel_err_out      = reset && sel_err_q;
endmodule

// File: doc/dispatch_router.md
Name: dispatch_router

Overview:
- Parametrised dispatch stage between rename and the issue queues.
- Buffers renamed instructions in a small FIFO and allocates a ROB tag to each one, tracking ROB occupancy internally.
- Routes each instruction to one of NUM_IQ issue queues with a valid/ready handshake.
- Flushes on mispredict and restores the ROB tail from the recovery pointer.

Parameters:
DATA_W, 64, width of the opaque renamed-instruction payload
NUM_IQ, 3, number of issue-queue channels
SEL_W, 2, width of the issue-queue select field (must be >= $clog2(NUM_IQ))
BUF_DEPTH, 4, input FIFO entries (power of 2, >=2)
ROB_DEPTH, 16, ROB entries (power of 2)
TAG_W, 5, ROB tag width = $clog2(ROB_DEPTH)+1; the MSB is the wrap bit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
valid_in  in  1  rename has an instruction
ready_out  out  1  dispatch can accept this cycle
data_in  in  DATA_W  renamed payload
sel_in  in  SEL_W  target issue queue index
iq_valid_out  out  NUM_IQ  one-hot valid toward issue queues
iq_ready_in  in  NUM_IQ  per-queue ready
iq_data_out  out  DATA_W  payload of FIFO head (shared by all queues)
iq_tag_out  out  TAG_W  ROB tag allocated to the head instruction
commit_in  in  1  ROB retired one entry this cycle (advances head)
mispredict  in  1  flush request
recover_tail_in  in  TAG_W  ROB tail to restore on mispredict
buf_count_out  out  $clog2(BUF_DEPTH)+1  FIFO occupancy
rob_count_out  out  TAG_W  ROB occupancy = tail - head (mod 2*ROB_DEPTH)
sel_err_out  out  1  sticky flag: an out-of-range sel was dropped

Behaviour:
Reset (reset==0 at a clk edge):
- FIFO empty; ROB head and tail = 0; sel_err_out = 0.
- While reset is low, all outputs are 0, including ready_out.
- ready_out = 1 in the first cycle after reset is released.

Accept side:
- ready_out = (buf_count < BUF_DEPTH) && !mispredict. It never depends on valid_in.
- Push on valid_in && ready_out. Payload and sel are written to the FIFO tail.
- A pushed entry is visible at the head no earlier than the next cycle. Minimum latency from accept to iq_valid_out is 1 cycle.

Dispatch side:
- head_ok = FIFO non-empty && rob_count < ROB_DEPTH && !mispredict.
- If the head sel < NUM_IQ: iq_valid_out[sel] = head_ok and all other bits are 0.
- iq_valid_out does not depend on iq_ready_in.
- fire = iq_valid_out[sel] && iq_ready_in[sel]. On fire: pop the FIFO and increment tail. iq_tag_out = current tail.
- At most one dispatch per cycle.
- If the head sel >= NUM_IQ and the FIFO is non-empty and there is no mispredict:
  - pop the entry with iq_valid_out all 0;
  - allocate no tag;
  - set sel_err_out (it clears only on reset).
- iq_data_out and iq_tag_out always reflect the head and the current tail (don't-care when no valid).

Simultaneous events:
- Push and pop in the same cycle: buf_count is unchanged.
- When full, no push even if a pop occurs that cycle.
- commit_in with rob_count == 0 is ignored.
- Commit and dispatch in the same cycle: head and tail both advance, so rob_count is unchanged.
- Pointers are TAG_W wide and wrap naturally. Full means tail - head == ROB_DEPTH.

Mispredict (single-cycle pulse, highest priority):
- That cycle: no push and no dispatch.
- Next state: FIFO emptied and tail = recover_tail_in.
- A commit_in in the same cycle still advances head.
- Resulting rob_count = recover_tail_in - new head.
- recover_tail_in must lie between head and the old tail inclusive. Otherwise behaviour is undefined.

Reset mid-operation overrides everything, including mispredict.

Test Plan:
- Basic flow: release reset, push 3 instructions with sel=0,1,2, all iq_ready_in=1. Required: iq_valid_out = 001, 010, 100 on consecutive cycles starting 1 cycle after the first accept; tags 0,1,2; rob_count reaches 3.
- FIFO backpressure: iq_ready_in=0, push continuously. Required: ready_out drops after 4 accepts and buf_count_out=4; raise iq_ready_in[0] and one pop per cycle frees one slot.
- ROB full: no commits, dispatch 16 instructions. Required: 17th head holds with iq_valid_out=0 and rob_count_out=16; one commit_in pulse lets it dispatch with tag 16 (wrap bit set, index 0).
- Mispredict: tail=10, head=4, FIFO holds 3; pulse mispredict with recover_tail_in=7 plus commit_in. Required: next cycle buf_count=0, rob_count=2, next dispatched tag=7.
- Bad select: push an entry with sel=3 (NUM_IQ=3). Required: popped with no iq_valid_out, tail unchanged, sel_err_out=1 until reset.
- Reset mid-stream with a full FIFO and rob_count=9: hold reset low 1 cycle. Required: all outputs 0 during reset; after release ready_out=1, counts 0, first tag 0.
